// File: rtl/alien_fleet_controller.sv
// alien_fleet_controller: marches, reverses/drops and accelerates the alien fleet, and schedules alien shots
//
// Optional feature macro: FLEET_SPEEDUP_EN (kill-driven march acceleration).
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   start                 one-cycle pulse that begins a wave (IDLE/CLEARED only)
//   alive, edge_hit       per-alien status from the alien array
//   landed                fleet reached the player row
//   fire_ready            bullet unit accepts the pending shot
//   movement_direction    0 = left, 1 = right
//   movement_frequency    cycles per step, broadcast to all aliens
//   movement_width        pixels per step, 0 halts the fleet
//   y_offset              cumulative fleet drop
//   armed, fire_valid     one-hot shooter grant and shot request
//   wave_cleared          high while in CLEARED
//   game_over             high while in OVER
module alien_fleet_controller #(
   parameter int          NUM_ALIENS     = 8,
   parameter logic [15:0] BASE_FREQUENCY = 16'd1000,
   parameter logic [15:0] MIN_FREQUENCY  = 16'd100,
   parameter logic [15:0] FREQ_STEP      = 16'd100,
   parameter logic [15:0] MOVE_WIDTH     = 16'd4,
   parameter logic [15:0] DROP_HEIGHT    = 16'd8,
   parameter logic [15:0] FIRE_INTERVAL  = 16'd500
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [NUM_ALIENS-1:0] alive,
   input  logic [NUM_ALIENS-1:0] edge_hit,
   input  logic                  landed,
   input  logic                  fire_ready,
   output logic                  movement_direction,
   output logic [15:0]           movement_frequency,
   output logic [15:0]           movement_width,
   output logic [15:0]           y_offset,
   output logic [NUM_ALIENS-1:0] armed,
   output logic                  fire_valid,
   output logic                  wave_cleared,
   output logic                  game_over
);
   localparam int PW = NUM_ALIENS > 1 ? $clog2(NUM_ALIENS) : 1;
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] MARCH   = 3'd1;
   localparam logic [2:0] DESCEND = 3'd2;
   localparam logic [2:0] CLEARED = 3'd3;
   localparam logic [2:0] OVER    = 3'd4;

   logic [2:0]    state, nxt;
   logic [16:0]   lockout;
   logic [15:0]   timer, freq_nxt;
   logic [PW-1:0] ptr, cur, pick, idx;
   logic          pick_ok, rev, go, waiting, moving_nxt;

   always_comb begin
      waiting    = state == IDLE || state == CLEARED;
      go         = waiting && start;
      rev        = state == MARCH && |(edge_hit & alive) && lockout == '0;
      nxt        = waiting ? (start ? MARCH : state) :
                   (state == MARCH || state == DESCEND) ?
                      (landed ? OVER : ~|alive ? CLEARED : rev ? DESCEND : MARCH) : state;
      moving_nxt = nxt == MARCH || nxt == DESCEND;
   end

   // Round-robin search: walk downward so the smallest offset from ptr wins.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      idx     = '0;
      for (int i = NUM_ALIENS - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr) + i) % NUM_ALIENS);
         if (alive[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

`ifdef FLEET_SPEEDUP_EN
   logic [NUM_ALIENS-1:0] prev_alive;
   logic [31:0]           kills, dec;

   // 32-bit arithmetic so kills*FREQ_STEP can never wrap before saturation.
   always_comb begin
      kills = '0;
      for (int i = 0; i < NUM_ALIENS; i++) kills = kills + 32'(prev_alive[i] & ~alive[i]);
      dec      = kills * 32'(FREQ_STEP);
      freq_nxt = 32'(movement_frequency) < dec + 32'(MIN_FREQUENCY) ? MIN_FREQUENCY :
                 movement_frequency - dec[15:0];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) prev_alive <= '0;
      else        prev_alive <= alive;
`else
   assign freq_nxt = BASE_FREQUENCY;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         movement_direction <= 1'b1;
         movement_frequency <= BASE_FREQUENCY;
         movement_width     <= '0;
         y_offset           <= '0;
         armed              <= '0;
         fire_valid         <= 1'b0;
         wave_cleared       <= 1'b0;
         game_over          <= 1'b0;
         lockout            <= '0;
         timer              <= '0;
         ptr                <= '0;
         cur                <= '0;
      end else begin
         state          <= nxt;
         movement_width <= nxt == MARCH ? MOVE_WIDTH : '0;
         wave_cleared   <= nxt == CLEARED;
         game_over      <= nxt == OVER;
         if (go) begin
            movement_frequency <= BASE_FREQUENCY;
            movement_direction <= 1'b1;
            y_offset           <= '0;
            ptr                <= '0;
            timer              <= '0;
            lockout            <= '0;
         end else begin
            movement_frequency <= freq_nxt;
            // Lockout spans one full step so the alien still on the boundary cannot re-trigger.
            if (rev) begin
               movement_direction <= ~movement_direction;
               y_offset           <= y_offset + DROP_HEIGHT;
               lockout            <= {1'b0, movement_frequency} + 17'd1;
            end else if ((state == MARCH || state == DESCEND) && lockout != '0)
               lockout <= lockout - 17'd1;
            if (fire_valid) begin
               if (fire_ready) begin
                  armed      <= '0;
                  fire_valid <= 1'b0;
                  timer      <= '0;
                  ptr        <= cur == PW'(NUM_ALIENS - 1) ? '0 : cur + 1'b1;
               end else if (!alive[cur] || !moving_nxt) begin
                  armed      <= '0;
                  fire_valid <= 1'b0;
                  timer      <= '0;
               end
            end else if (state == MARCH) begin
               if (timer == FIRE_INTERVAL - 16'd1) begin
                  timer <= '0;
                  if (pick_ok) begin
                     armed      <= NUM_ALIENS'(1) << pick;
                     fire_valid <= 1'b1;
                     cur        <= pick;
                  end
               end else
                  timer <= timer + 16'd1;
            end
         end
      end
   end
endmodule

// File: doc/alien_fleet_controller.md
# alien_fleet_controller

Sequencer for the alien fleet: it drives the shared movement controls (direction, frequency, step width) into every alien instance and reverses and drops the fleet when any alien reports an edge hit. It also accelerates the march as aliens are destroyed and schedules alien shots through a round-robin `armed` grant with a valid/ready handshake to the bullet unit. It sits between the alien array and the game top level, which supplies `start` and `landed` and consumes `wave_cleared` and `game_over`.

## Interface
- `NUM_ALIENS`, 8 — aliens under control; width of the vector ports.
- `BASE_FREQUENCY`, 16'd1000 — cycles per step at wave start.
- `MIN_FREQUENCY`, 16'd100 — speed-up floor.
- `FREQ_STEP`, 16'd100 — frequency reduction per kill.
- `MOVE_WIDTH`, 16'd4 — pixels per step while marching.
- `DROP_HEIGHT`, 16'd8 — pixels added to `y_offset` per reversal.
- `FIRE_INTERVAL`, 16'd500 — marching cycles between shot requests.

Ports:
- `clk` in 1 — sole clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle pulse that begins a wave.
- `alive` in NUM_ALIENS — alive vector from the alien array.
- `edge_hit` in NUM_ALIENS — per-alien `movement` outputs.
- `landed` in 1 — fleet reached the player row.
- `fire_ready` in 1 — bullet unit can accept a shot.
- `movement_direction` out 1 — 0 = left, 1 = right.
- `movement_frequency` out 16 — step period, broadcast to all aliens.
- `movement_width` out 16 — step size; 0 halts the fleet.
- `y_offset` out 16 — cumulative fleet drop.
- `armed` out NUM_ALIENS — one-hot shooter grant, or all zero.
- `fire_valid` out 1 — shot request pending.
- `wave_cleared` out 1 — high in CLEARED.
- `game_over` out 1 — high in OVER.

## Operation
- FSM states: IDLE, MARCH, DESCEND, CLEARED, OVER. All outputs are registered.
- Reset values: state IDLE, `movement_direction`=1, `movement_frequency`=BASE_FREQUENCY, `movement_width`=0, `y_offset`=0, `armed`=0, `fire_valid`=0, `wave_cleared`=0, `game_over`=0, lockout=0, fire timer=0, round-robin pointer=0.
- IDLE/CLEARED + `start`:
  - Go to MARCH.
  - Reload frequency=BASE, direction=1, `y_offset`=0, pointer=0, timer=0.
- MARCH:
  - `movement_width`=MOVE_WIDTH; in every other state `movement_width`=0.
  - A reversal is `|(edge_hit & alive)` with lockout==0. It goes to DESCEND, toggles direction, adds DROP_HEIGHT to `y_offset` (wrapping mod 2^16), and loads lockout with `movement_frequency`+1.
- DESCEND: lasts one cycle, then returns to MARCH. Lockout decrements to 0 in MARCH and DESCEND.
- Exit priority, evaluated in MARCH/DESCEND: `landed` → OVER, then `alive`==0 → CLEARED, then reversal.
- OVER is left only by `rst_n`; `start` is ignored there and in MARCH.
- Speed-up: kills = popcount(prev_alive & ~alive), counted every cycle.
  - New frequency = max(MIN_FREQUENCY, freq − kills×FREQ_STEP).
  - Compute in at least 20 bits and saturate; never underflow.
- Fire scheduler:
  - The timer counts only in MARCH.
  - At FIRE_INTERVAL−1 with no request pending, select the first alive index at or after the pointer, circularly, and assert that `armed` bit and `fire_valid`.
  - If no alien is alive, make no request and restart the timer.
  - While pending, `armed`/`fire_valid` hold stable until `fire_valid & fire_ready`. The next cycle then clears both, sets pointer = chosen+1 mod NUM_ALIENS, and zeroes the timer.
  - If the armed alien dies while pending, or the state leaves MARCH/DESCEND, withdraw: clear both next cycle and zero the timer; the pointer is unchanged.

## Timing
- A reversal sampled at cycle N gives DESCEND, new direction and new `y_offset` visible at N+1, and MARCH again at N+2.
- Edge hits during lockout are ignored; this absorbs the duplicate flag from the alien still at the boundary.
- A kill at cycle N gives the updated `movement_frequency` at N+1.
- Timer expiry at cycle N asserts `fire_valid` at N+1. A handshake at M deasserts it at M+1.
- `start` coincident with `landed` in IDLE: `start` wins; `landed` is then evaluated from MARCH.
- `rst_n` low mid-operation returns all outputs to their reset values immediately (asynchronous).

## Configuration
- `FLEET_SPEEDUP_EN` defined: kill-driven acceleration as specified above.
- `FLEET_SPEEDUP_EN` undefined: `movement_frequency` is constantly BASE_FREQUENCY and the kill-count logic is absent.

## Test plan
- Reset, then `start`, `alive`=8'hFF → `movement_width`=4, direction=1, frequency=1000 from the next cycle; `armed`=0.
- `edge_hit`=8'h80 for 2 consecutive cycles → one DESCEND only: direction=0, `y_offset`=8; second pulse ignored (lockout=1001).
- `alive` 8'hFF→8'hFC in one cycle → frequency 800 next cycle. Repeated kills leave frequency at 100, never below. With the macro undefined it stays 1000.
- After 500 MARCH cycles, pointer=0 and `alive`=8'hFE → `armed`=8'h02, `fire_valid`=1 held for 3 cycles with `fire_ready`=0. Handshake → both clear; next grant goes to the first alive index ≥2.
- Armed alien killed while pending → `fire_valid`=0 next cycle, timer restarts, pointer unchanged.
- `alive`=0 → `wave_cleared`=1 and `movement_width`=0. `landed`=1 in MARCH → `game_over`=1, `start` ignored until `rst_n`.
